// File: rtl/gearbox_param.sv
// Parametrised LSB-first bit-stream gearbox: IN_W-bit words in, OUT_W-bit words out,
// through a BUF_W-bit linear shift accumulator. Define GEARBOX_FLUSH_EN to add the flush/pad input.
module gearbox_param #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20,
    parameter int BUF_W = 64,
    parameter int LVL_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [IN_W-1:0]  data_in,
    input  logic             shift_in,
    output logic             full,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             shift_out,
    output logic [LVL_W-1:0] level,
    output logic             ovf_err,
`ifdef GEARBOX_FLUSH_EN
    output logic             unf_err,
    input  logic             flush
`else
    output logic             unf_err
`endif
);

    localparam logic [LVL_W-1:0] FULL_TH = LVL_W'(BUF_W - IN_W);
    localparam logic [LVL_W-1:0] OUT_LVL = LVL_W'(OUT_W);
    localparam logic [LVL_W-1:0] IN_LVL  = LVL_W'(IN_W);

    if (BUF_W < IN_W + OUT_W - 1) begin : g_size_chk
        $error("gearbox_param: BUF_W must be >= IN_W+OUT_W-1");
    end

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push, pop;

    // Outputs decode from registers only, so neither handshake can fall through.
    assign full      = (level_q > FULL_TH);
    assign valid_out = (level_q >= OUT_LVL);
    assign data_out  = buf_q[OUT_W-1:0];
    assign level     = level_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

    assign push = shift_in && !full;
    assign pop  = shift_out && valid_out;

    always_comb begin
        buf_d   = buf_q;
        level_d = level_q;
        ovf_d   = ovf_q | (shift_in && full);
        unf_d   = unf_q | (shift_out && !valid_out);
        // Pop first; the right shift zero-fills, keeping every bit above level at 0.
        if (pop) begin
            buf_d   = buf_q >> OUT_W;
            level_d = level_q - OUT_LVL;
        end
        // Bits at and above level_d are zero, so OR-ing the new word in is a write.
        if (push) begin
            buf_d   = buf_d | (BUF_W'(data_in) << level_d);
            level_d = level_d + IN_LVL;
        end
`ifdef GEARBOX_FLUSH_EN
        // Pad a partial word: upper bits are already zero, only the level moves.
        if (flush && !shift_in && (level_q != '0) && (level_q < OUT_LVL)) begin
            level_d = OUT_LVL;
        end
`endif
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            buf_q   <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_gearbox_param.sv
// Scoreboard bench: directed vectors on the default 16->20 gearbox plus a random
// push/pop stream through a 20->16 instance checked bit-for-bit against a bit queue.
module tb_gearbox_param;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance: IN_W=16, OUT_W=20, BUF_W=64
    logic [15:0] data_in = '0;
    logic        shift_in = 1'b0;
    logic        full, valid_out, ovf_err, unf_err;
    logic [19:0] data_out;
    logic [6:0]  level;
    logic        pop_auto = 1'b0, pop_raw = 1'b0;
    logic        shift_out;
    logic        flush = 1'b0;
    assign shift_out = pop_raw | (pop_auto & valid_out);

    gearbox_param dut (
        .clk(clk), .res_n(res_n), .data_in(data_in), .shift_in(shift_in),
        .full(full), .data_out(data_out), .valid_out(valid_out),
        .shift_out(shift_out), .level(level), .ovf_err(ovf_err),
`ifdef GEARBOX_FLUSH_EN
        .unf_err(unf_err), .flush(flush)
`else
        .unf_err(unf_err)
`endif
    );

    // Parametric instance: IN_W=20, OUT_W=16, BUF_W=40
    logic [19:0] data_in2 = '0;
    logic        shift_in2 = 1'b0;
    logic        full2, valid_out2, ovf_err2, unf_err2;
    logic [15:0] data_out2;
    logic [5:0]  level2;
    logic        pop_en2 = 1'b0;
    logic        shift_out2;
    logic        flush2 = 1'b0;
    assign shift_out2 = pop_en2 & valid_out2;

    gearbox_param #(.IN_W(20), .OUT_W(16), .BUF_W(40)) dut2 (
        .clk(clk), .res_n(res_n), .data_in(data_in2), .shift_in(shift_in2),
        .full(full2), .data_out(data_out2), .valid_out(valid_out2),
        .shift_out(shift_out2), .level(level2), .ovf_err(ovf_err2),
`ifdef GEARBOX_FLUSH_EN
        .unf_err(unf_err2), .flush(flush2)
`else
        .unf_err(unf_err2)
`endif
    );

    int          n_vec = 0, n_mis = 0;
    logic [19:0] expq[$];
    bit          bq[$];
    logic        rnd_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the default instance
    always @(negedge clk) begin
        if (res_n && shift_out && valid_out) begin
            if (expq.size() == 0) chk("dut1 unexpected word", {44'd0, data_out}, 64'hdead);
            else chk("dut1 word", {44'd0, data_out}, {44'd0, expq.pop_front()});
        end
    end

    // Bit-level model for the parametric instance: pop old bits, then append accepted ones
    always @(negedge clk) begin
        if (rnd_on && res_n) begin
            logic [15:0] w;
            chk("dut2 level", {58'd0, level2}, 64'(bq.size()));
            if (shift_out2 && valid_out2) begin
                if (bq.size() < 16) chk("dut2 underrun", 64'(bq.size()), 64'd16);
                else begin
                    for (int i = 0; i < 16; i++) w[i] = bq.pop_front();
                    chk("dut2 word", {48'd0, data_out2}, {48'd0, w});
                end
            end
            if (shift_in2 && !full2)
                for (int i = 0; i < 20; i++) bq.push_back(data_in2[i]);
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 res_n = 1'b0;
        shift_in = 1'b0; pop_auto = 1'b0; pop_raw = 1'b0; flush = 1'b0;
        @(negedge clk); #2 res_n = 1'b1;
    endtask

    task automatic push1(input logic [15:0] w);
        @(posedge clk); #1 data_in = w; shift_in = 1'b1;
        @(posedge clk); #1 shift_in = 1'b0;
    endtask

    task automatic wait_level(input int tgt, input int budget, input string name);
        int k = 0;
        while (int'(level) != tgt && k < budget) begin @(negedge clk); k++; end
        chk(name, {57'd0, level}, 64'(tgt));
    endtask

    task automatic stream_t1(input string tag);
        logic [15:0] w[5] = '{16'h4321, 16'h8765, 16'hCBA9, 16'h0FED, 16'h3210};
        expq.push_back(20'h54321); expq.push_back(20'hA9876);
        expq.push_back(20'hFEDCB); expq.push_back(20'h32100);
        pop_auto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 data_in = w[i]; shift_in = 1'b1;
        end
        @(posedge clk); #1 shift_in = 1'b0;
        wait_level(0, 20, {tag, " final level"});
        pop_auto = 1'b0;
        chk({tag, " words left"}, 64'(expq.size()), 64'd0);
        chk({tag, " errs"}, {62'd0, ovf_err, unf_err}, 64'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset outs", {full, valid_out, ovf_err, unf_err, level, data_out}, 64'd0);
        @(negedge clk); #2 res_n = 1'b1;

        // 1: continuous stream
        stream_t1("t1");

        // 2: partial word, pop requested while not valid
        do_reset();
        pop_raw = 1'b1;
        push1(16'h4321);
        @(negedge clk); @(negedge clk);
        chk("t2 valid", {63'd0, valid_out}, 64'd0);
        chk("t2 level", {57'd0, level}, 64'd16);
        chk("t2 unf", {63'd0, unf_err}, 64'd1);
        pop_raw = 1'b0;

        // 3: fill to capacity, drop on full, drain
        do_reset();
        begin
            logic [15:0] w[4] = '{16'h4321, 16'h8765, 16'hCBA9, 16'hAFED};
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1 data_in = w[i]; shift_in = 1'b1;
            end
            @(posedge clk); #1 shift_in = 1'b0;
        end
        @(negedge clk);
        chk("t3 level full", {57'd0, level}, 64'd64);
        chk("t3 full", {63'd0, full}, 64'd1);
        chk("t3 ovf before", {63'd0, ovf_err}, 64'd0);
        push1(16'h5555);
        @(negedge clk);
        chk("t3 level kept", {57'd0, level}, 64'd64);
        chk("t3 ovf", {63'd0, ovf_err}, 64'd1);
        expq.push_back(20'h54321); expq.push_back(20'hA9876); expq.push_back(20'hFEDCB);
        pop_auto = 1'b1;
        wait_level(4, 20, "t3 remainder");
        repeat (2) @(negedge clk);
        pop_auto = 1'b0;
        chk("t3 words left", 64'(expq.size()), 64'd0);
        chk("t3 valid", {63'd0, valid_out}, 64'd0);
        chk("t3 zero fill", {44'd0, data_out}, 64'h0000A);
        chk("t3 unf", {63'd0, unf_err}, 64'd0);

        // 4: asynchronous reset mid-stream
        do_reset();
        @(posedge clk); #1 pop_raw = 1'b1;
        @(posedge clk); #1 pop_raw = 1'b0; data_in = 16'h4321; shift_in = 1'b1;
        @(posedge clk); #1 data_in = 16'h8765;
        @(posedge clk); #1 shift_in = 1'b0;
        @(negedge clk);
        chk("t4 pre level", {57'd0, level}, 64'd32);
        chk("t4 pre unf", {63'd0, unf_err}, 64'd1);
        #2 res_n = 1'b0;
        #1 chk("t4 async reset", {full, valid_out, ovf_err, unf_err, level, data_out}, 64'd0);
        #6 res_n = 1'b1;
        stream_t1("t4 restart");

`ifdef GEARBOX_FLUSH_EN
        // 5: flush pads a partial word
        do_reset();
        @(posedge clk); #1 data_in = 16'h4321; shift_in = 1'b1;
        @(posedge clk); #1 shift_in = 1'b0; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("t5 valid", {63'd0, valid_out}, 64'd1);
        chk("t5 data", {44'd0, data_out}, 64'h04321);
        expq.push_back(20'h04321);
        pop_auto = 1'b1;
        wait_level(0, 5, "t5 level");
        pop_auto = 1'b0;
        chk("t5 words left", 64'(expq.size()), 64'd0);
`endif

        // 6: random push/pop through the 20->16 instance
        do_reset();
        rnd_on = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1
            data_in2  = 20'($urandom);
            shift_in2 = ($urandom_range(0, 3) != 0);
            pop_en2   = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 shift_in2 = 1'b0; pop_en2 = 1'b1;
        repeat (8) @(posedge clk);
        #1 pop_en2 = 1'b0;
        @(negedge clk);
        rnd_on = 1'b0;
        chk("t6 residue", {58'd0, level2}, 64'(bq.size()));
        chk("t6 drained", {63'd0, valid_out2}, 64'd0);
        chk("t6 unf", {63'd0, unf_err2}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
